// File: rtl/router_pkg.sv
// Shared types and header-field layout for the 1x3 router controller.
package router_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EMPTY,
        LOAD_HDR,
        LOAD_DATA,
        CHECK,
        DROP
    } ctrl_state_t;

    localparam int NUM_CH = 3;

    localparam logic [1:0] ADDR_INVALID = 2'd3;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    // Payload byte counter stops at its maximum rather than wrapping.
    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (v == 6'h3f) ? v : v + 6'd1;
    endfunction

endpackage

// File: rtl/router_ctrl_if.sv
// Source-port and FIFO-side signals of the router controller.
interface router_ctrl_if #(parameter int DATA_W = 8);
    import router_pkg::*;

    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] read_enb;
    logic              busy;
    logic              error;
    logic [NUM_CH-1:0] write_enb;
    logic [DATA_W-1:0] fifo_din;
    logic [NUM_CH-1:0] valid_out;
    logic [NUM_CH-1:0] soft_reset;

    // Environment side: source, FIFOs and readers.
    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
        input  busy, error, write_enb, fifo_din, valid_out, soft_reset
    );

    // Controller side.
    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
        output busy, error, write_enb, fifo_din, valid_out, soft_reset
    );

endinterface

// File: rtl/router_sync_timer.sv
// Per-channel idle-reader watchdog: flushes a FIFO whose data sits unread.
module router_sync_timer #(
    parameter int TIMEOUT = 30
) (
    input  logic clock,
    input  logic resetn,
    input  logic valid_i,
    input  logic read_i,
    input  logic empty_i,
    output logic soft_reset_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sr_q, sr_d;

    // Count un-read cycles; fire a single pulse and restart on the TIMEOUT-th one.
    always_comb begin
        cnt_d = cnt_q;
        sr_d  = 1'b0;
        if (read_i || empty_i) begin
            cnt_d = '0;
        end else if (valid_i) begin
            if (cnt_q == CW'(TIMEOUT - 1)) begin
                cnt_d = '0;
                sr_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            sr_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

    assign soft_reset_o = sr_q;

endmodule

// File: rtl/router_ctrl.sv
// Packet sequencer for the 1x3 router: steers packets to FIFOs, checks
// parity/length, back-pressures the source and runs the channel watchdogs.
module router_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = 30,
    parameter int DATA_W  = 8
) (
    input  logic           clock,
    input  logic           resetn,
    router_ctrl_if.slave   bus
);

    ctrl_state_t       state_q;
    logic [DATA_W-1:0] hdr_q;
    logic [1:0]        addr_q;
    logic [5:0]        len_q;
    logic [DATA_W-1:0] par_q;
    logic [5:0]        cnt_q;
    logic              perr_q;
    logic              error_q;

    logic [1:0]        hdr_addr;
    logic [3:0]        full_ext;
    logic [3:0]        empty_ext;
    logic              ch_full;
    logic              ch_empty;
    logic [NUM_CH-1:0] ch_sel;
    logic [NUM_CH-1:0] sr;

    // Pad per-channel flags to 4 entries so the invalid address 3 indexes safely.
    assign hdr_addr  = bus.data_in[HDR_ADDR_MSB:HDR_ADDR_LSB];
    assign full_ext  = {1'b0, bus.fifo_full};
    assign empty_ext = {1'b1, bus.fifo_empty};
    assign ch_full   = full_ext[addr_q];
    assign ch_empty  = empty_ext[addr_q];
    assign ch_sel    = NUM_CH'(4'b0001 << addr_q);

    // Sequencer: header capture, FIFO wait, load, check and drop paths.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            hdr_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            par_q   <= '0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.pkt_valid) begin
                        hdr_q   <= bus.data_in;
                        addr_q  <= hdr_addr;
                        len_q   <= bus.data_in[HDR_LEN_MSB:HDR_LEN_LSB];
                        error_q <= 1'b0;
                        if (hdr_addr == ADDR_INVALID)
                            state_q <= DROP;
                        else if (empty_ext[hdr_addr])
                            state_q <= LOAD_HDR;
                        else
                            state_q <= WAIT_EMPTY;
                    end
                end
                WAIT_EMPTY: begin
                    if (ch_empty)
                        state_q <= LOAD_HDR;
                end
                LOAD_HDR: begin
                    par_q   <= hdr_q;
                    cnt_q   <= '0;
                    state_q <= LOAD_DATA;
                end
                LOAD_DATA: begin
                    // A full FIFO stalls everything; the source holds the byte.
                    if (!ch_full) begin
                        if (bus.pkt_valid) begin
                            par_q <= par_q ^ bus.data_in;
                            cnt_q <= sat_inc6(cnt_q);
                        end else begin
                            perr_q  <= (bus.data_in != par_q);
                            state_q <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    error_q <= perr_q | (cnt_q != len_q);
                    state_q <= IDLE;
                end
                DROP: begin
                    error_q <= 1'b1;
                    if (!bus.pkt_valid)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Back-pressure and FIFO write path follow the state within the cycle.
    always_comb begin
        bus.busy      = 1'b0;
        bus.write_enb = '0;
        bus.fifo_din  = '0;
        case (state_q)
            WAIT_EMPTY: bus.busy = 1'b1;
            LOAD_HDR: begin
                bus.busy      = 1'b1;
                bus.write_enb = ch_sel;
                bus.fifo_din  = hdr_q;
            end
            LOAD_DATA: begin
                bus.busy     = ch_full;
                bus.fifo_din = bus.data_in;
                if (!ch_full)
                    bus.write_enb = ch_sel;
            end
            CHECK: bus.busy = 1'b1;
            default: ;
        endcase
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_tmr
        router_sync_timer #(.TIMEOUT(TIMEOUT)) u_tmr (
            .clock        (clock),
            .resetn       (resetn),
            .valid_i      (~bus.fifo_empty[i]),
            .read_i       (bus.read_enb[i]),
            .empty_i      (bus.fifo_empty[i]),
            .soft_reset_o (sr[i])
        );
    end

    assign bus.error      = error_q;
    assign bus.soft_reset = sr;
    assign bus.valid_out  = ~bus.fifo_empty;

endmodule

// File: tb/tb_router_ctrl.sv
// Directed bench for router_ctrl: per-cycle vectors with hand-computed outputs.
module tb_router_ctrl;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    router_ctrl_if bus ();

    router_ctrl #(.TIMEOUT(30), .DATA_W(8)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    localparam logic [2:0] Z  = 3'b000;
    localparam logic [2:0] E  = 3'b111;
    localparam logic [2:0] NE = 3'b101;
    localparam logic [2:0] F  = 3'b100;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One clock cycle: apply inputs, check combinational/registered outputs, advance.
    task automatic cyc(input string tag, input logic pv, input logic [7:0] d,
                       input logic [2:0] full, input logic [2:0] empty,
                       input logic ebusy, input logic [2:0] ewe,
                       input logic [7:0] edin, input logic eerr);
        bus.pkt_valid  = pv;
        bus.data_in    = d;
        bus.fifo_full  = full;
        bus.fifo_empty = empty;
        #2;
        chk({tag, ".busy"}, 32'(bus.busy), 32'(ebusy));
        chk({tag, ".we"}, 32'(bus.write_enb), 32'(ewe));
        if (ewe != 3'b000)
            chk({tag, ".din"}, 32'(bus.fifo_din), 32'(edin));
        chk({tag, ".err"}, 32'(bus.error), 32'(eerr));
        chk({tag, ".sr"}, 32'(bus.soft_reset), 32'd0);
        tick();
    endtask

    initial begin
        bus.pkt_valid  = 1'b0;
        bus.data_in    = 8'h00;
        bus.fifo_full  = Z;
        bus.fifo_empty = E;
        bus.read_enb   = Z;

        // Reset state
        #3;
        chk("rst0.busy", 32'(bus.busy), 32'd0);
        chk("rst0.err", 32'(bus.error), 32'd0);
        chk("rst0.we", 32'(bus.write_enb), 32'd0);
        chk("rst0.din", 32'(bus.fifo_din), 32'd0);
        chk("rst0.sr", 32'(bus.soft_reset), 32'd0);
        bus.fifo_empty = 3'b010;
        #1;
        chk("rst0.valid_out", 32'(bus.valid_out), 32'h5);
        bus.fifo_empty = E;
        #20;
        tick();
        resetn = 1'b1;

        // Clean packet: ch0, length 5, parity 0x05
        cyc("clean.hdr",  1, 8'h14, Z, E, 0, Z,      8'h00, 0);
        cyc("clean.lhdr", 1, 8'h11, Z, E, 1, 3'b001, 8'h14, 0);
        cyc("clean.p0",   1, 8'h11, Z, E, 0, 3'b001, 8'h11, 0);
        cyc("clean.p1",   1, 8'h22, Z, E, 0, 3'b001, 8'h22, 0);
        cyc("clean.p2",   1, 8'h33, Z, E, 0, 3'b001, 8'h33, 0);
        cyc("clean.p3",   1, 8'h44, Z, E, 0, 3'b001, 8'h44, 0);
        cyc("clean.p4",   1, 8'h55, Z, E, 0, 3'b001, 8'h55, 0);
        cyc("clean.par",  0, 8'h05, Z, E, 0, 3'b001, 8'h05, 0);
        cyc("clean.chk",  0, 8'h00, Z, E, 1, Z,      8'h00, 0);
        cyc("clean.idle", 0, 8'h00, Z, E, 0, Z,      8'h00, 0);

        // Bad parity: 0x04 instead of 0x05
        cyc("bad.hdr",   1, 8'h14, Z, E, 0, Z,      8'h00, 0);
        cyc("bad.lhdr",  1, 8'h11, Z, E, 1, 3'b001, 8'h14, 0);
        cyc("bad.p0",    1, 8'h11, Z, E, 0, 3'b001, 8'h11, 0);
        cyc("bad.p1",    1, 8'h22, Z, E, 0, 3'b001, 8'h22, 0);
        cyc("bad.p2",    1, 8'h33, Z, E, 0, 3'b001, 8'h33, 0);
        cyc("bad.p3",    1, 8'h44, Z, E, 0, 3'b001, 8'h44, 0);
        cyc("bad.p4",    1, 8'h55, Z, E, 0, 3'b001, 8'h55, 0);
        cyc("bad.par",   0, 8'h04, Z, E, 0, 3'b001, 8'h04, 0);
        cyc("bad.chk",   0, 8'h00, Z, E, 1, Z,      8'h00, 0);
        cyc("bad.idle0", 0, 8'h00, Z, E, 0, Z,      8'h00, 1);
        cyc("bad.idle1", 0, 8'h00, Z, E, 0, Z,      8'h00, 1);

        // Short payload: length 5 but 4 bytes, parity consistent (0x50)
        cyc("short.hdr",  1, 8'h14, Z, E, 0, Z,      8'h00, 1);
        cyc("short.lhdr", 1, 8'h11, Z, E, 1, 3'b001, 8'h14, 0);
        cyc("short.p0",   1, 8'h11, Z, E, 0, 3'b001, 8'h11, 0);
        cyc("short.p1",   1, 8'h22, Z, E, 0, 3'b001, 8'h22, 0);
        cyc("short.p2",   1, 8'h33, Z, E, 0, 3'b001, 8'h33, 0);
        cyc("short.p3",   1, 8'h44, Z, E, 0, 3'b001, 8'h44, 0);
        cyc("short.par",  0, 8'h50, Z, E, 0, 3'b001, 8'h50, 0);
        cyc("short.chk",  0, 8'h00, Z, E, 1, Z,      8'h00, 0);
        cyc("short.idle", 0, 8'h00, Z, E, 0, Z,      8'h00, 1);

        // Invalid address 3: dropped, never busy, error raised
        cyc("inv.hdr",  1, 8'h0B, Z, E, 0, Z, 8'h00, 1);
        cyc("inv.d0",   1, 8'hAA, Z, E, 0, Z, 8'h00, 0);
        cyc("inv.d1",   1, 8'hBB, Z, E, 0, Z, 8'h00, 1);
        cyc("inv.par",  0, 8'h1A, Z, E, 0, Z, 8'h00, 1);
        cyc("inv.idle", 0, 8'h00, Z, E, 0, Z, 8'h00, 1);

        // Destination ch1 not empty: wait, then header the cycle after empty rises
        cyc("ne.hdr", 1, 8'h09, Z, NE, 0, Z, 8'h00, 1);
        for (int k = 0; k < 10; k++)
            cyc("ne.wait", 1, 8'h5A, Z, NE, 1, Z, 8'h00, 0);
        cyc("ne.rise", 1, 8'h5A, Z, E, 1, Z,      8'h00, 0);
        cyc("ne.lhdr", 1, 8'h5A, Z, E, 1, 3'b010, 8'h09, 0);
        cyc("ne.p0",   1, 8'h5A, Z, E, 0, 3'b010, 8'h5A, 0);
        cyc("ne.p1",   1, 8'hA5, Z, E, 0, 3'b010, 8'hA5, 0);
        cyc("ne.par",  0, 8'hF6, Z, E, 0, 3'b010, 8'hF6, 0);
        cyc("ne.chk",  0, 8'h00, Z, E, 1, Z,      8'h00, 0);
        cyc("ne.idle", 0, 8'h00, Z, E, 0, Z,      8'h00, 0);

        // ch2 full for 3 payload cycles and during the parity byte
        cyc("full.hdr",  1, 8'h12, Z, E, 0, Z,      8'h00, 0);
        cyc("full.lhdr", 1, 8'h01, Z, E, 1, 3'b100, 8'h12, 0);
        cyc("full.p0",   1, 8'h01, Z, E, 0, 3'b100, 8'h01, 0);
        cyc("full.st0",  1, 8'h02, F, E, 1, Z,      8'h00, 0);
        cyc("full.st1",  1, 8'h02, F, E, 1, Z,      8'h00, 0);
        cyc("full.st2",  1, 8'h02, F, E, 1, Z,      8'h00, 0);
        cyc("full.p1",   1, 8'h02, Z, E, 0, 3'b100, 8'h02, 0);
        cyc("full.p2",   1, 8'h03, Z, E, 0, 3'b100, 8'h03, 0);
        cyc("full.p3",   1, 8'h04, Z, E, 0, 3'b100, 8'h04, 0);
        cyc("full.pst",  0, 8'h16, F, E, 1, Z,      8'h00, 0);
        cyc("full.par",  0, 8'h16, Z, E, 0, 3'b100, 8'h16, 0);
        cyc("full.chk",  0, 8'h00, Z, E, 1, Z,      8'h00, 0);
        cyc("full.idle", 0, 8'h00, Z, E, 0, Z,      8'h00, 0);

        // Timeout: ch0 valid and unread for 30 cycles
        bus.fifo_empty = 3'b110;
        bus.read_enb   = Z;
        for (int k = 1; k <= 30; k++) begin
            #2;
            chk("tmo.quiet", 32'(bus.soft_reset), 32'd0);
            tick();
        end
        #2;
        chk("tmo.pulse", 32'(bus.soft_reset), 32'h1);
        chk("tmo.valid", 32'(bus.valid_out), 32'h1);
        tick();
        #2;
        chk("tmo.one_shot", 32'(bus.soft_reset), 32'd0);
        tick();
        bus.fifo_empty = E;
        tick();
        tick();

        // A read at cycle 29 restarts the count: no pulse in the window
        bus.fifo_empty = 3'b110;
        for (int k = 1; k <= 45; k++) begin
            bus.read_enb = (k == 29) ? 3'b001 : 3'b000;
            #2;
            chk("tmo.read_rescue", 32'(bus.soft_reset), 32'd0);
            tick();
        end
        bus.read_enb   = Z;
        bus.fifo_empty = E;
        tick();

        // Reset mid-packet while stalled in the payload phase
        cyc("rst.hdr",  1, 8'h14, Z, E, 0, Z,      8'h00, 0);
        cyc("rst.lhdr", 1, 8'h11, Z, E, 1, 3'b001, 8'h14, 0);
        cyc("rst.p0",   1, 8'h11, Z, E, 0, 3'b001, 8'h11, 0);
        bus.data_in   = 8'h22;
        bus.fifo_full = 3'b001;
        #2;
        chk("rst.pre_busy", 32'(bus.busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.we", 32'(bus.write_enb), 32'd0);
        chk("rst.din", 32'(bus.fifo_din), 32'd0);
        chk("rst.err", 32'(bus.error), 32'd0);
        chk("rst.sr", 32'(bus.soft_reset), 32'd0);
        bus.fifo_empty = 3'b010;
        #1;
        chk("rst.valid_out", 32'(bus.valid_out), 32'h5);
        bus.fifo_empty = E;
        tick();
        resetn = 1'b1;
        // Remaining source byte 0x22 is taken as a header for ch2
        cyc("rst.rehdr",  1, 8'h22, Z, E, 0, Z,      8'h00, 0);
        cyc("rst.as_hdr", 1, 8'h33, Z, E, 1, 3'b100, 8'h22, 0);
        bus.pkt_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/router_ctrl.md
# router_ctrl

Packet-sequencing controller for the 1x3 router. It sits between the source port (`data_in`/`pkt_valid`/`busy`/`error`) and the three destination FIFOs. It:
- decodes the header byte and steers each packet into the addressed FIFO;
- back-pressures the source via `busy`;
- checks parity and length, and reports `error`;
- drives per-channel `valid_out`;
- soft-resets any FIFO whose data has been ignored by its reader for `TIMEOUT` cycles.

## Interface
Parameters:
- `TIMEOUT`, default 30: consecutive un-read cycles before a channel soft reset.
- `DATA_W`, default 8: byte width. Only 8 is supported.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `pkt_valid` in 1: source byte valid. High from header through last payload byte.
- `data_in` in 8: source byte.
- `fifo_full` in 3: per-channel FIFO full.
- `fifo_empty` in 3: per-channel FIFO empty.
- `read_enb` in 3: per-channel read enable from the destination side.
- `busy` out 1: source must hold the current byte while high.
- `error` out 1: last packet failed its parity or length check.
- `write_enb` out 3: one-hot FIFO write strobe.
- `fifo_din` out 8: byte to the FIFOs.
- `valid_out` out 3: equals `~fifo_empty`, combinational.
- `soft_reset` out 3: one-cycle FIFO flush pulse per channel.

## Operation
Packet format:
- Header: `[1:0]` is the destination (0–2; 3 is invalid), `[7:2]` is the payload length (0–63).
- Then the payload bytes.
- Then the parity byte, which equals the XOR of header and all payload bytes. The parity byte is presented in the first cycle `pkt_valid` is low after the payload.

FSM states (`IDLE`, `WAIT_EMPTY`, `LOAD_HDR`, `LOAD_DATA`, `CHECK`, `DROP`):
- **IDLE**: `busy`=0.
  - On `pkt_valid`, capture the header into `hdr_reg`, the destination into `addr_reg`, and the length.
  - If destination = 3: go to `DROP`.
  - Else if `fifo_empty[addr]`: go to `LOAD_HDR`.
  - Else: go to `WAIT_EMPTY`.
- **WAIT_EMPTY**: `busy`=1. Go to `LOAD_HDR` when `fifo_empty[addr_reg]`.
- **LOAD_HDR**: `busy`=1.
  - Write `hdr_reg` (`write_enb[addr_reg]`=1, `fifo_din`=`hdr_reg`).
  - Initialise the parity accumulator to `hdr_reg` and the byte count to 0.
  - Go to `LOAD_DATA`.
- **LOAD_DATA**: `busy` = `fifo_full[addr_reg]`, combinational.
  - If not full: write `data_in`.
  - If `pkt_valid`: XOR the byte into the parity accumulator and increment the count.
  - If `!pkt_valid`: the byte is the parity byte. Compare it, and go to `CHECK` after it is written.
  - While full: no write and no state change. The source holds the byte, including the parity byte.
- **CHECK**: `busy`=1. Register `error` = (parity mismatch) OR (count ≠ length). Go to `IDLE`.
- **DROP**: `busy`=0, no writes. Set `error`=1. Go to `IDLE` on the first cycle `pkt_valid` is low.

Error and timers:
- `error` holds its value until the next header is captured in `IDLE`; it clears to 0 on that capture.
- Per-channel timer `i`:
  - Counts while `valid_out[i] && !read_enb[i]`.
  - Clears on `read_enb[i]` or `fifo_empty[i]`.
  - On reaching `TIMEOUT`, pulses `soft_reset[i]` and clears.
- A soft reset of the channel being loaded does not alter the FSM; remaining bytes are still written.

## Timing
- Reset, asynchronous: state = `IDLE`; `busy`, `error`, `write_enb`, `fifo_din`, `soft_reset`, all counters and `hdr_reg` = 0. `valid_out` follows `fifo_empty` even in reset.
- Reset mid-packet: takes effect immediately. The rest of the source packet is seen in `IDLE`, so its next byte is treated as a header.
- `write_enb`/`fifo_din` are combinational from the state plus inputs. The FIFO captures on the same edge the byte is accepted.
- Minimum packet latency: header to first write is 1 cycle. A packet with N payload bytes occupies N+4 cycles (`IDLE`, `LOAD_HDR`, N×`LOAD_DATA`, parity, `CHECK`) when there is no back-pressure.
- `busy` is combinational; the source samples it before the edge.
- The parity accumulator is 8-bit XOR. The count is 6-bit, saturating at 63.

## Structure
- `router_pkg`:
  - state enum `ctrl_state_t`;
  - `ADDR_INVALID` = 2'd3;
  - header field constants `HDR_ADDR_LSB`/`MSB` and `HDR_LEN_LSB`/`MSB`.
- Sub-module `router_sync_timer`: one per channel, instantiated 3×, with `TIMEOUT` passed through.

## Test plan
- **Clean packet**: header 0x14 (ch0, length 5), 5 payload bytes, correct parity, ch0 empty → exactly 7 `write_enb[0]` pulses; `fifo_din` sequence matches; `busy` high only in `LOAD_HDR` and `CHECK`; `error`=0.
- **Bad parity**: same packet with parity XOR 0x01 → `error`=1 from the cycle after `CHECK`, held until the next header; a short payload (4 bytes, length 5) also gives `error`=1.
- **Invalid address**: header 0x0B (addr 3) → no `write_enb`, `busy`=0 throughout, `error`=1.
- **Destination not empty**: header for ch1 while `fifo_empty[1]`=0 for 10 cycles → `busy`=1 for those cycles, header written the cycle after empty rises.
- **FIFO full mid-payload**: `fifo_full[2]` high for 3 cycles mid-payload, and also during the parity byte → no writes, `busy`=1 for exactly those cycles; each byte is written exactly once.
- **Timeout**: `valid_out[0]`=1 with `read_enb[0]`=0 for 30 cycles → `soft_reset[0]` pulses on cycle 30; a `read_enb[0]` pulse at cycle 29 → no pulse.
- **Reset mid-packet**: `resetn` low during `LOAD_DATA` → all outputs 0 immediately.
